// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: collects 32-bit big-endian words into 16-word
// blocks, applies the 0x80 / zero-fill / 64-bit bit-length padding, and
// streams each block as 16 words followed by idle cycles so every block
// occupies BLOCK_CYCLES cycles of the downstream schedule.
//
// Handshake: a word transfers on a rising clk edge when in_valid & in_ready.
// in_ready depends only on the state register and is high only in FILL. A
// source that sees in_ready low must hold its word until in_ready returns.
//
// Output timing: M, start, blk_last and busy are registers loaded with the
// values for the state the FSM enters. This keeps them aligned with the
// state, so start and word 0 appear in the first EMIT cycle.
module sha_msg_padder #(
  parameter int BLOCK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        in_ready,
  output logic [31:0] M,
  output logic        start,
  output logic        blk_last,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(BLOCK_CYCLES);
  localparam logic [CW-1:0] LAST_CYC = CW'(BLOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [4:0]     idx, idx_nx;          // next buffer slot, 16 = full
  logic [63:0]    len, len_nx;          // message length in bits
  logic [CW-1:0]  cyc, cyc_nx;          // cycle within an emitted block
  logic           extra, extra_nx;      // length words go in a follow-on block
  logic           need80, need80_nx;    // 0x80 marker still to be written
  logic           final_blk, final_nx;  // last word of the message received
  logic [31:0]    m_nx;
  logic           start_nx, blk_last_nx, busy_nx;
  logic           go_emit;

  logic [31:0]    mem [16];
  logic           mem_we, mem_clr;
  logic [3:0]     mem_widx;
  logic [31:0]    mem_wdata;

  logic [2:0]     bcnt;
  logic [31:0]    last_word;
  logic [4:0]     pos80;
  logic [CW:0]    cyc_inc;

  assign in_ready  = (state == S_FILL);
  assign dbg_state = state;

  // Byte count of the final word (values above 4 act as a full word), the
  // masked final word with its 0x80 marker, and where the marker lands.
  always_comb begin
    bcnt = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    case (bcnt)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
    pos80   = (bcnt == 3'd4) ? idx + 5'd1 : idx;
    cyc_inc = {1'b0, cyc} + (CW + 1)'(1);
  end

  // Next-state, buffer write control and next output values.
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    len_nx      = len;
    cyc_nx      = cyc;
    extra_nx    = extra;
    need80_nx   = need80;
    final_nx    = final_blk;
    m_nx        = 32'h0;
    start_nx    = 1'b0;
    blk_last_nx = blk_last;
    busy_nx     = busy;
    go_emit     = 1'b0;
    mem_we      = 1'b0;
    mem_clr     = 1'b0;
    mem_widx    = idx[3:0];
    mem_wdata   = in_data;

    case (state)
      S_FILL: begin
        if (in_valid) begin
          busy_nx = 1'b1;
          mem_we  = 1'b1;
          idx_nx  = idx + 5'd1;
          if (in_last) begin
            mem_wdata = last_word;
            len_nx    = len + {58'b0, bcnt, 3'b000};
            final_nx  = 1'b1;
            need80_nx = (bcnt == 3'd4);
            extra_nx  = (pos80 > 5'd13);
            state_nx  = S_PAD;
          end else begin
            len_nx = len + 64'd32;
            if (idx == 5'd15) go_emit = 1'b1;
          end
        end
      end

      S_PAD: begin
        if (idx == 5'd16) begin
          go_emit = 1'b1;
        end else begin
          mem_we = 1'b1;
          if (need80)                          mem_wdata = 32'h8000_0000;
          else if (!extra && idx == 5'd14)     mem_wdata = len[63:32];
          else if (!extra && idx == 5'd15)     mem_wdata = len[31:0];
          else                                 mem_wdata = 32'h0;
          need80_nx = 1'b0;
          idx_nx    = idx + 5'd1;
          if (idx == 5'd15) go_emit = 1'b1;
        end
      end

      S_EMIT: begin
        if (cyc == LAST_CYC) begin
          if (extra) begin
            // Follow-on block: zeros, pending marker in word 0, length at 14/15.
            mem_clr     = 1'b1;
            extra_nx    = 1'b0;
            need80_nx   = 1'b0;
            cyc_nx      = '0;
            start_nx    = 1'b1;
            blk_last_nx = 1'b1;
            m_nx        = need80 ? 32'h8000_0000 : 32'h0;
          end else begin
            state_nx    = S_FILL;
            idx_nx      = 5'd0;
            blk_last_nx = 1'b0;
            if (final_blk) begin
              busy_nx  = 1'b0;
              len_nx   = 64'd0;
              final_nx = 1'b0;
            end
          end
        end else begin
          cyc_nx = cyc_inc[CW-1:0];
          if (cyc_inc < (CW + 1)'(16)) m_nx = mem[cyc_inc[3:0]];
        end
      end

      default: state_nx = S_FILL;
    endcase

    if (go_emit) begin
      state_nx    = S_EMIT;
      cyc_nx      = '0;
      start_nx    = 1'b1;
      m_nx        = mem[0];
      blk_last_nx = final_blk & ~extra;
    end
  end

  // Control state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FILL;
      idx       <= 5'd0;
      len       <= 64'd0;
      cyc       <= '0;
      extra     <= 1'b0;
      need80    <= 1'b0;
      final_blk <= 1'b0;
      M         <= 32'h0;
      start     <= 1'b0;
      blk_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      len       <= len_nx;
      cyc       <= cyc_nx;
      extra     <= extra_nx;
      need80    <= need80_nx;
      final_blk <= final_nx;
      M         <= m_nx;
      start     <= start_nx;
      blk_last  <= blk_last_nx;
      busy      <= busy_nx;
    end
  end

  // Block buffer; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0]  <= need80 ? 32'h8000_0000 : 32'h0;
      mem[14] <= len[63:32];
      mem[15] <= len[31:0];
    end else if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
Producer side of the SHA-256 message schedule interface. Accepts a big-endian 32-bit word stream with a valid/ready handshake and buffers 16 words per block. Applies SHA-256 padding (0x80 byte, zero fill, 64-bit bit-length). Emits each 512-bit block as 16 consecutive M words, with a start pulse aligned to word 0, then holds 48 idle cycles so each block occupies exactly 64 cycles of the downstream schedule/compression core.

Parameters:
BLOCK_CYCLES, 64, cycles per emitted block (16 data + 48 idle); must be >= 16.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_data  input  32  message word; first byte in [31:24]
in_valid  input  1  in_data valid
in_last  input  1  word is final word of message
in_bytes  input  3  valid bytes in a last word (1-4; 0 only for an empty message); ignored when in_last=0
in_ready  output  1  padder accepts a word this cycle
M  output  32  message word to schedule
start  output  1  1-cycle pulse with word 0 of a block; drives the schedule's restart input
blk_last  output  1  high for all 64 cycles of a message's final block
busy  output  1  high from first accepted word until the final block's last idle cycle

Behaviour:
- Reset (async): state FILL, word index 0, length counter 0, in_ready=1, M=0, start=0, blk_last=0, busy=0. Buffer contents are don't-care.
- Handshake: a word transfers on a rising edge with in_valid&in_ready. in_ready=1 only in FILL. Gaps in in_valid stall FILL indefinitely.
- Length: 64-bit bit counter, +32 per non-last word, +8*in_bytes on the last word; wraps mod 2^64.
- States:
  - FILL: store the word at the current index; index++.
    - Non-last word at index 15 -> EMIT.
    - Last word: mask unused bytes to 0 and put 0x80 in the first unused byte. If in_bytes=4, the 0x80 goes in byte [31:24] of the next index. Then -> PAD.
  - PAD: one word per cycle, in_ready=0. Zero words until index 14. Words 14/15 get length[63:32]/length[31:0] if the 0x80 byte landed at word index <=13. Otherwise zeros through 15 and an extra block is flagged. -> EMIT at index 16.
  - EMIT: cycle counter c = 0..63.
    - c=0: start=1, M=word0.
    - c<16: M=word[c].
    - c>=16: M=0.
    - At c=63: if the extra block is flagged, clear the buffer to zeros with length at 14/15, clear the flag, and go to EMIT again with blk_last=1. Else if the block was final, go to FILL with busy=0. Else go to FILL with index 0.
- blk_last=1 during EMIT of the block containing the length words only.
- Empty message: in_last=1 with in_bytes=0 at index 0 gives word0=0x80000000; the rest is zero and the length is 0.
- After the final block, the length counter clears to 0 for the next message.
- M/start/blk_last are registered outputs, with no combinational path from in_*.
- Reset mid-EMIT/PAD: outputs drop to reset values immediately; no further start pulse.
- in_valid while in_ready=0: ignored, not lost (the source holds it).

Test Plan:
- "abc": one word 0x61626300, in_last=1, in_bytes=3 -> PAD, then start with M=0x61626380. Words 1-14 are 0, word15=0x00000018, blk_last=1 for 64 cycles, busy drops at the end.
- Empty message (in_bytes=0) -> M word0=0x80000000, words1-15=0, single block, blk_last=1.
- 14 full words (56 bytes), last in_bytes=4 -> block1: word14=0x80000000, word15=0, blk_last=0. Block2 starts exactly 64 cycles after block1's start: words0-13=0, word14=0, word15=0x000001C0, blk_last=1.
- 20 words with random in_valid gaps -> block1 = the first 16 words verbatim with in_ready=0 during its 64 EMIT cycles. Block2 = words 16-19, 0x80000000, zeros, word15=0x00000280. start is high exactly once per block.
- Reset asserted at EMIT c=10 -> outputs M=0, start=0, busy=0 asynchronously, in_ready=1. A new "abc" message then produces the correct single block.
- Back-to-back messages ("abc" then empty) -> the second message's length word is 0, proving the counter clears between messages.
